control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 iClk  in  1  single system clock; all state changes on rising edge.
REQ-002 nRst  in  1  synchronous, active-low reset, sampled on iClk rising edge.
REQ-003 iMemData  in  32  instruction word from memory, valid when iMemRdy=1.
REQ-004 iMemRdy  in  1  memory completion strobe for the current oMemRead/oMemWrite.
REQ-005 iJ_zero, iJ_nZero, iJ_pos, iJ_neg  in  1 each  datapath branch-condition flags on the RA register.
REQ-006 oMemRead, oMemWrite  out  1 each  memory request, held until iMemRdy=1.
REQ-007 oPC_nRst, oPC_en, oPC_jmp, oPC_loadRA, oPC_loadImm  out  1 each  program counter control.
REQ-008 oRF_Write  out  1; oRF_AddrA, oRF_AddrB, oRF_AddrC  out  4 each  register file control.
REQ-009 oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en, oRWB_en  out  1 each  datapath register enables.
REQ-010 oALU_Ctrl  out  4  ALU operation, encoded with the CTRL_ALU_* values.
REQ-011 oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_WBP, oMUX_MAP, oMUX_ASS  out  1 each  datapath mux selects.
REQ-012 oImm32  out  32  sign-extended constant field of IR.
REQ-013 oHalt  out  1  set in HALT state.

Function
REQ-014 IR fields SHALL be: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C IR[18:0]. oImm32 = C sign-extended from bit 18. Branch condition = IR[20:19]: 00 zero, 01 nZero, 10 pos, 11 neg.
REQ-015 Supported opcodes (ISA_* values) SHALL be: ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, ADDI, ANDI, ORI, LD, ST, BR, NOP, HALT. Any other opcode SHALL enter HALT.
REQ-016 States: RESET, FETCH, DECODE, EXEC, WBLATCH, MEM, WBWRITE, HALT. All outputs SHALL be Moore functions of state and IR. Every output not listed for a state SHALL be 0.
REQ-017 RESET: oPC_nRst=0. Next state SHALL be FETCH.
REQ-018 FETCH: oMemRead=1, oMUX_MAP=1. On iMemRdy=1: IR<=iMemData, next state DECODE. Otherwise stay in FETCH with IR unchanged.
REQ-019 DECODE: oPC_en=1 (PC+1), oRA_en=1, oRB_en=1, oRF_AddrA=Rb, oRF_AddrB=Rc. Immediate classes (ADDI/ANDI/ORI/LD/ST) SHALL set oMUX_BIS=1. ST SHALL set oRF_AddrB=Ra; BR SHALL set oRF_AddrA=Ra. NOP SHALL go to FETCH; HALT opcode SHALL go to HALT; all other opcodes SHALL go to EXEC.
REQ-020 EXEC (ALU, immediate, LD, ST): oALU_Ctrl = the matching CTRL_ALU_* value (ADD for LD/ST), oMUX_BIS held, oRZH_en=1, oRZL_en=1. Next state SHALL be WBLATCH for ALU/immediate opcodes and MEM for LD/ST.
REQ-021 EXEC for BR: if the selected iJ_* flag is 1, then oPC_en=1, oPC_jmp=1 and oPC_loadImm=1 for exactly this cycle (PC += oImm32). Next state SHALL be FETCH.
REQ-022 WBLATCH: oRWB_en=1 with oMUX_WBM=0, oMUX_WBP=0, oMUX_RZHS=0, oMUX_ASS=0. Next state SHALL be WBWRITE.
REQ-023 MEM: oMUX_MAP=0, with oMemRead=1 (LD) or oMemWrite=1 (ST) held until iMemRdy=1. On the iMemRdy=1 cycle, LD SHALL assert oRWB_en=1 with oMUX_WBM=1 and go to WBWRITE; ST SHALL go to FETCH.
REQ-024 WBWRITE: oRF_Write=1, oRF_AddrC=Ra. Next state SHALL be FETCH.
REQ-025 HALT: oHalt=1, all enables and requests 0; the state SHALL hold until reset.
REQ-026 Latency with zero-wait memory SHALL be 5 cycles FETCH-to-FETCH for ALU/immediate/LD, 4 for ST, 3 for BR, 2 for NOP. Each wait cycle SHALL add exactly one cycle.
REQ-027 iMemRdy SHALL be ignored outside FETCH and MEM. iJ_* SHALL be ignored outside EXEC for BR.

Reset
REQ-028 nRst=0 at an edge SHALL force state RESET and IR=0 from any state, including mid-MEM and mid-WBWRITE. No oRF_Write, oMemWrite or oPC_en SHALL be asserted in the following cycle.
REQ-029 While in RESET all outputs SHALL be 0 except oRF_Addr*=0; oPC_nRst=0 throughout.

Verification
REQ-030 Hold nRst=0 for 2 cycles, then release -> oPC_nRst=0 through the first post-release cycle; the next cycle shows FETCH with oMemRead=1, oMUX_MAP=1, oPC_nRst=1.
REQ-031 AND R4,R3,R7 with iMemRdy=1 -> DECODE: AddrA=3, AddrB=7, RA/RB_en, PC_en; EXEC: ALU_Ctrl=CTRL_ALU_AND, RZH/RZL_en; WBLATCH: RWB_en; WBWRITE: RF_Write, AddrC=4; FETCH again at cycle 5.
REQ-032 FETCH with iMemRdy=0 for 3 cycles -> state stays FETCH, oMemRead held 4 cycles, no oPC_en; IR is loaded on the 4th cycle.
REQ-033 LD R2,0x10(R5) with 2 wait states -> oMUX_BIS=1, oImm32=0x00000010, AddrA=5; MEM holds oMemRead 3 cycles; RWB_en+MUX_WBM on the 3rd; then RF_Write, AddrC=2.
REQ-034 BR zero, C=-4: iJ_zero=1 -> PC_en/PC_jmp/PC_loadImm for 1 cycle with oImm32=0xFFFFFFFC; iJ_zero=0 -> no PC signals; both return to FETCH.
REQ-035 Undefined opcode -> HALT, oHalt=1 held for 10 cycles, no enables. Reset asserted mid-MEM of a ST -> no oMemWrite after the reset edge.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control unit for a small load/store CPU.
// Fetches a 32-bit instruction word into IR, decodes it and steps the
// datapath through the execute, write-back-latch, memory and register-write
// phases. Outputs are decoded from the current state and IR. The only
// exceptions are the MEM completion cycle, which also looks at iMemRdy, and
// the BR execute cycle, which also looks at the selected iJ_* flag.
//
// Ports
//   iClk, nRst            clock, synchronous active-low reset
//   iMemData, iMemRdy     instruction/memory return word and completion strobe
//   iJ_zero/nZero/pos/neg branch-condition flags for register RA
//   oMemRead, oMemWrite   memory requests, held until iMemRdy
//   oPC_*                 program counter control (oPC_nRst is active low)
//   oRF_*                 register file write enable and addresses
//   oR*_en                datapath register enables
//   oALU_Ctrl             ALU operation (CTRL_ALU_*)
//   oMUX_*                datapath mux selects
//   oImm32                sign-extended C field of IR
//   oHalt                 processor halted
module control_sequencer (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy,
  input  logic        iJ_zero,
  input  logic        iJ_nZero,
  input  logic        iJ_pos,
  input  logic        iJ_neg,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oPC_nRst,
  output logic        oPC_en,
  output logic        oPC_jmp,
  output logic        oPC_loadRA,
  output logic        oPC_loadImm,
  output logic        oRF_Write,
  output logic [3:0]  oRF_AddrA,
  output logic [3:0]  oRF_AddrB,
  output logic [3:0]  oRF_AddrC,
  output logic        oRA_en,
  output logic        oRB_en,
  output logic        oRZH_en,
  output logic        oRZL_en,
  output logic        oRAS_en,
  output logic        oRWB_en,
  output logic [3:0]  oALU_Ctrl,
  output logic        oMUX_BIS,
  output logic        oMUX_RZHS,
  output logic        oMUX_WBM,
  output logic        oMUX_WBP,
  output logic        oMUX_MAP,
  output logic        oMUX_ASS,
  output logic [31:0] oImm32,
  output logic        oHalt
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned ALU_W  = 4;
  localparam int unsigned C_W    = 19;
  localparam int unsigned WORD_W = 32;

  localparam logic [OP_W-1:0] ISA_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ISA_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ISA_AND  = 5'd2;
  localparam logic [OP_W-1:0] ISA_OR   = 5'd3;
  localparam logic [OP_W-1:0] ISA_SHR  = 5'd4;
  localparam logic [OP_W-1:0] ISA_SHL  = 5'd5;
  localparam logic [OP_W-1:0] ISA_ROR  = 5'd6;
  localparam logic [OP_W-1:0] ISA_ROL  = 5'd7;
  localparam logic [OP_W-1:0] ISA_ADDI = 5'd8;
  localparam logic [OP_W-1:0] ISA_ANDI = 5'd9;
  localparam logic [OP_W-1:0] ISA_ORI  = 5'd10;
  localparam logic [OP_W-1:0] ISA_LD   = 5'd11;
  localparam logic [OP_W-1:0] ISA_ST   = 5'd12;
  localparam logic [OP_W-1:0] ISA_BR   = 5'd13;
  localparam logic [OP_W-1:0] ISA_NOP  = 5'd14;
  localparam logic [OP_W-1:0] ISA_HALT = 5'd15;

  localparam logic [ALU_W-1:0] CTRL_ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] CTRL_ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] CTRL_ALU_AND = 4'd2;
  localparam logic [ALU_W-1:0] CTRL_ALU_OR  = 4'd3;
  localparam logic [ALU_W-1:0] CTRL_ALU_SHR = 4'd4;
  localparam logic [ALU_W-1:0] CTRL_ALU_SHL = 4'd5;
  localparam logic [ALU_W-1:0] CTRL_ALU_ROR = 4'd6;
  localparam logic [ALU_W-1:0] CTRL_ALU_ROL = 4'd7;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_WBLATCH, S_MEM, S_WBWRITE, S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d;

  // IR field decode
  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] ra_f, rb_f, rc_f;
  logic [1:0]       cond_f;
  assign opcode = ir_q[31:27];
  assign ra_f   = ir_q[26:23];
  assign rb_f   = ir_q[22:19];
  assign rc_f   = ir_q[18:15];
  assign cond_f = ir_q[20:19];
  assign oImm32 = {{(WORD_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

  logic is_ld, is_st, is_br, is_nop, is_stop, uses_imm, br_taken;
  logic [ALU_W-1:0] alu_op;
  assign is_ld    = (opcode == ISA_LD);
  assign is_st    = (opcode == ISA_ST);
  assign is_br    = (opcode == ISA_BR);
  assign is_nop   = (opcode == ISA_NOP);
  // HALT opcode and every unassigned opcode both stop the machine
  assign is_stop  = (opcode >= ISA_HALT);
  assign uses_imm = (opcode == ISA_ADDI) || (opcode == ISA_ANDI) ||
                    (opcode == ISA_ORI) || is_ld || is_st;

  // ALU operation for the execute phase; memory ops use ADD for the address
  always_comb begin
    alu_op = CTRL_ALU_ADD;
    case (opcode)
      ISA_SUB:            alu_op = CTRL_ALU_SUB;
      ISA_AND, ISA_ANDI:  alu_op = CTRL_ALU_AND;
      ISA_OR,  ISA_ORI:   alu_op = CTRL_ALU_OR;
      ISA_SHR:            alu_op = CTRL_ALU_SHR;
      ISA_SHL:            alu_op = CTRL_ALU_SHL;
      ISA_ROR:            alu_op = CTRL_ALU_ROR;
      ISA_ROL:            alu_op = CTRL_ALU_ROL;
      default:            alu_op = CTRL_ALU_ADD;
    endcase
  end

  // Branch condition select
  always_comb begin
    case (cond_f)
      2'b00:   br_taken = iJ_zero;
      2'b01:   br_taken = iJ_nZero;
      2'b10:   br_taken = iJ_pos;
      default: br_taken = iJ_neg;
    endcase
  end

  // State and instruction register
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state_q <= S_RESET;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and IR load
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_RESET:   state_d = S_FETCH;
      S_FETCH: begin
        if (iMemRdy) begin
          ir_d    = iMemData;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_nop)       state_d = S_FETCH;
        else if (is_stop) state_d = S_HALT;
        else              state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_br)               state_d = S_FETCH;
        else if (is_ld || is_st) state_d = S_MEM;
        else                     state_d = S_WBLATCH;
      end
      S_WBLATCH: state_d = S_WBWRITE;
      S_MEM: begin
        if (iMemRdy) state_d = is_ld ? S_WBWRITE : S_FETCH;
      end
      S_WBWRITE: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RESET;
    endcase
  end

  // Output decode; oPC_nRst is active low and only pulled down in RESET
  always_comb begin
    oMemRead    = 1'b0;
    oMemWrite   = 1'b0;
    oPC_nRst    = 1'b1;
    oPC_en      = 1'b0;
    oPC_jmp     = 1'b0;
    oPC_loadRA  = 1'b0;
    oPC_loadImm = 1'b0;
    oRF_Write   = 1'b0;
    oRF_AddrA   = '0;
    oRF_AddrB   = '0;
    oRF_AddrC   = '0;
    oRA_en      = 1'b0;
    oRB_en      = 1'b0;
    oRZH_en     = 1'b0;
    oRZL_en     = 1'b0;
    oRAS_en     = 1'b0;
    oRWB_en     = 1'b0;
    oALU_Ctrl   = '0;
    oMUX_BIS    = 1'b0;
    oMUX_RZHS   = 1'b0;
    oMUX_WBM    = 1'b0;
    oMUX_WBP    = 1'b0;
    oMUX_MAP    = 1'b0;
    oMUX_ASS    = 1'b0;
    oHalt       = 1'b0;
    case (state_q)
      S_RESET: oPC_nRst = 1'b0;
      S_FETCH: begin
        oMemRead = 1'b1;
        oMUX_MAP = 1'b1;
      end
      S_DECODE: begin
        oPC_en    = 1'b1;
        oRA_en    = 1'b1;
        oRB_en    = 1'b1;
        oRF_AddrA = is_br ? ra_f : rb_f;
        oRF_AddrB = is_st ? ra_f : rc_f;
        oMUX_BIS  = uses_imm;
      end
      S_EXEC: begin
        if (is_br) begin
          oPC_en      = br_taken;
          oPC_jmp     = br_taken;
          oPC_loadImm = br_taken;
        end else begin
          oALU_Ctrl = alu_op;
          oMUX_BIS  = uses_imm;
          oRZH_en   = 1'b1;
          oRZL_en   = 1'b1;
        end
      end
      S_WBLATCH: oRWB_en = 1'b1;
      S_MEM: begin
        oMemRead  = is_ld;
        oMemWrite = is_st;
        // Load data is captured on the completion cycle itself
        oRWB_en   = is_ld && iMemRdy;
        oMUX_WBM  = is_ld && iMemRdy;
      end
      S_WBWRITE: begin
        oRF_Write = 1'b1;
        oRF_AddrC = ra_f;
      end
      S_HALT:  oHalt = 1'b1;
      default: oPC_nRst = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: each instruction is expanded into the
// cycle-by-cycle output pattern its class must produce (fetch waits, decode,
// execute, memory waits, write-back), then driven and compared every cycle.
module tb_control_sequencer;

  typedef struct packed {
    logic        mem_rd, mem_wr, pc_nrst, pc_en, pc_jmp, pc_ldra, pc_ldimm, rf_wr;
    logic [3:0]  addr_a, addr_b, addr_c;
    logic        ra_en, rb_en, rzh_en, rzl_en, ras_en, rwb_en;
    logic [3:0]  alu;
    logic        bis, rzhs, wbm, wbp, map, ass, halt;
    logic [31:0] imm;
  } outs_t;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3;
  localparam logic [4:0] OP_SHR = 5'd4, OP_SHL = 5'd5, OP_ROR = 5'd6, OP_ROL = 5'd7;
  localparam logic [4:0] OP_ADDI = 5'd8, OP_ANDI = 5'd9, OP_ORI = 5'd10;
  localparam logic [4:0] OP_LD = 5'd11, OP_ST = 5'd12, OP_BR = 5'd13;
  localparam logic [4:0] OP_NOP = 5'd14, OP_HALT = 5'd15;

  logic        iClk = 1'b0;
  logic        nRst = 1'b0;
  logic [31:0] iMemData = '0;
  logic        iMemRdy = 1'b0;
  logic        iJ_zero = 1'b0, iJ_nZero = 1'b0, iJ_pos = 1'b0, iJ_neg = 1'b0;
  logic        oMemRead, oMemWrite, oPC_nRst, oPC_en, oPC_jmp, oPC_loadRA, oPC_loadImm;
  logic        oRF_Write;
  logic [3:0]  oRF_AddrA, oRF_AddrB, oRF_AddrC;
  logic        oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en, oRWB_en;
  logic [3:0]  oALU_Ctrl;
  logic        oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_WBP, oMUX_MAP, oMUX_ASS;
  logic [31:0] oImm32;
  logic        oHalt;

  control_sequencer dut (
    .iClk(iClk), .nRst(nRst), .iMemData(iMemData), .iMemRdy(iMemRdy),
    .iJ_zero(iJ_zero), .iJ_nZero(iJ_nZero), .iJ_pos(iJ_pos), .iJ_neg(iJ_neg),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oPC_nRst(oPC_nRst), .oPC_en(oPC_en),
    .oPC_jmp(oPC_jmp), .oPC_loadRA(oPC_loadRA), .oPC_loadImm(oPC_loadImm),
    .oRF_Write(oRF_Write), .oRF_AddrA(oRF_AddrA), .oRF_AddrB(oRF_AddrB),
    .oRF_AddrC(oRF_AddrC), .oRA_en(oRA_en), .oRB_en(oRB_en), .oRZH_en(oRZH_en),
    .oRZL_en(oRZL_en), .oRAS_en(oRAS_en), .oRWB_en(oRWB_en), .oALU_Ctrl(oALU_Ctrl),
    .oMUX_BIS(oMUX_BIS), .oMUX_RZHS(oMUX_RZHS), .oMUX_WBM(oMUX_WBM),
    .oMUX_WBP(oMUX_WBP), .oMUX_MAP(oMUX_MAP), .oMUX_ASS(oMUX_ASS),
    .oImm32(oImm32), .oHalt(oHalt)
  );

  always #5 iClk = ~iClk;

  outs_t obs;
  always_comb begin
    obs          = '0;
    obs.mem_rd   = oMemRead;
    obs.mem_wr   = oMemWrite;
    obs.pc_nrst  = oPC_nRst;
    obs.pc_en    = oPC_en;
    obs.pc_jmp   = oPC_jmp;
    obs.pc_ldra  = oPC_loadRA;
    obs.pc_ldimm = oPC_loadImm;
    obs.rf_wr    = oRF_Write;
    obs.addr_a   = oRF_AddrA;
    obs.addr_b   = oRF_AddrB;
    obs.addr_c   = oRF_AddrC;
    obs.ra_en    = oRA_en;
    obs.rb_en    = oRB_en;
    obs.rzh_en   = oRZH_en;
    obs.rzl_en   = oRZL_en;
    obs.ras_en   = oRAS_en;
    obs.rwb_en   = oRWB_en;
    obs.alu      = oALU_Ctrl;
    obs.bis      = oMUX_BIS;
    obs.rzhs     = oMUX_RZHS;
    obs.wbm      = oMUX_WBM;
    obs.wbp      = oMUX_WBP;
    obs.map      = oMUX_MAP;
    obs.ass      = oMUX_ASS;
    obs.halt     = oHalt;
    obs.imm      = oImm32;
  end

  int n_asserts = 0;
  int n_fail    = 0;

  // Expected per-cycle pattern of the instruction being run, plus its stimulus
  outs_t       exp_q[$];
  bit          rdy_q[$];
  logic [31:0] data_q[$];
  logic [3:0]  flg_q[$];
  logic [31:0] model_ir = '0;

  function automatic logic [31:0] sext(input logic [31:0] ir);
    return {{13{ir[18]}}, ir[18:0]};
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      OP_SUB:          return 4'd1;
      OP_AND, OP_ANDI: return 4'd2;
      OP_OR,  OP_ORI:  return 4'd3;
      OP_SHR:          return 4'd4;
      OP_SHL:          return 4'd5;
      OP_ROR:          return 4'd6;
      OP_ROL:          return 4'd7;
      default:         return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [3:0] a, b, c);
    return {op, a, b, c, 15'h0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [3:0] a, b,
                                        input logic [18:0] k);
    return {op, a, b, k};
  endfunction

  function automatic logic [31:0] enc_br(input logic [3:0] a, input logic [1:0] cond,
                                         input logic [18:0] k);
    return {OP_BR, a, 2'b00, cond, k};
  endfunction

  function automatic outs_t idle_outs(input logic [31:0] ir);
    outs_t o = '0;
    o.pc_nrst = 1'b1;
    o.imm     = sext(ir);
    return o;
  endfunction

  task automatic push(input outs_t o, input bit rdy, input logic [31:0] d, input logic [3:0] f);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
    data_q.push_back(d);
    flg_q.push_back(f);
  endtask

  // Build the expected cycle pattern for one instruction from its class
  task automatic plan(input logic [31:0] ir, input int wf, input int wm, input logic [3:0] bflags);
    outs_t      o;
    logic [4:0] op = ir[31:27];
    logic [3:0] ra = ir[26:23], rb = ir[22:19], rc = ir[18:15];
    bit is_ld = (op == OP_LD), is_st = (op == OP_ST), is_br = (op == OP_BR);
    bit is_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || is_ld || is_st;
    exp_q.delete(); rdy_q.delete(); data_q.delete(); flg_q.delete();
    for (int i = 0; i <= wf; i++) begin
      o = idle_outs(model_ir); o.mem_rd = 1'b1; o.map = 1'b1;
      push(o, i == wf, (i == wf) ? ir : $urandom, 4'($urandom));
    end
    model_ir = ir;
    o = idle_outs(ir);
    o.pc_en = 1'b1; o.ra_en = 1'b1; o.rb_en = 1'b1; o.bis = is_imm;
    o.addr_a = is_br ? ra : rb;
    o.addr_b = is_st ? ra : rc;
    push(o, 1'($urandom), $urandom, 4'($urandom));
    if (op == OP_NOP) return;
    if (op >= OP_HALT) begin
      o = idle_outs(ir); o.halt = 1'b1;
      repeat (10) push(o, 1'($urandom), $urandom, 4'($urandom));
      return;
    end
    o = idle_outs(ir);
    if (is_br) begin
      o.pc_en = bflags[ir[20:19]]; o.pc_jmp = o.pc_en; o.pc_ldimm = o.pc_en;
      push(o, 1'($urandom), $urandom, bflags);
      return;
    end
    o.alu = alu_of(op); o.bis = is_imm; o.rzh_en = 1'b1; o.rzl_en = 1'b1;
    push(o, 1'($urandom), $urandom, 4'($urandom));
    if (is_ld || is_st) begin
      for (int i = 0; i <= wm; i++) begin
        o = idle_outs(ir); o.mem_rd = is_ld; o.mem_wr = is_st;
        o.rwb_en = is_ld && (i == wm); o.wbm = o.rwb_en;
        push(o, i == wm, $urandom, 4'($urandom));
      end
      if (is_st) return;
    end else begin
      o = idle_outs(ir); o.rwb_en = 1'b1;
      push(o, 1'($urandom), $urandom, 4'($urandom));
    end
    o = idle_outs(ir); o.rf_wr = 1'b1; o.addr_c = ra;
    push(o, 1'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic check(input outs_t e, input string tag);
    n_asserts++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic drive(input int i);
    iMemRdy  = rdy_q[i];
    iMemData = data_q[i];
    {iJ_neg, iJ_pos, iJ_nZero, iJ_zero} = flg_q[i];
  endtask

  // Run the first n cycles of the planned pattern (called just after an edge)
  task automatic run_plan(input int n, input string tag);
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      drive(i);
      @(negedge iClk);
      check(exp_q[i], tag);
      @(posedge iClk); #1;
    end
  endtask

  task automatic run_all(input string tag);
    run_plan(exp_q.size(), tag);
  endtask

  // Reset held for `hold` edges, then one released RESET cycle, then FETCH
  task automatic do_reset(input int hold, input string tag);
    nRst = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge iClk); #1;
      iMemRdy = 1'($urandom); iMemData = $urandom;
      @(negedge iClk);
      check('0, tag);
    end
    @(posedge iClk); #1;
    nRst = 1'b1;
    @(negedge iClk);
    check('0, tag);
    @(posedge iClk); #1;
    model_ir = '0;
  endtask

  // Assert reset during cycle k of the planned pattern
  task automatic reset_mid(input int k, input string tag);
    run_plan(k, tag);
    drive(k);
    nRst = 1'b0;
    @(negedge iClk);
    check(exp_q[k], tag);
    @(posedge iClk); #1;
    nRst = 1'b1;
    iMemRdy = 1'b1;
    @(negedge iClk);
    check('0, {tag, "_after"});
    @(posedge iClk); #1;
    model_ir = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ir;
    @(posedge iClk); #1;
    do_reset(1, "reset");

    plan(enc_r(OP_AND, 4'd4, 4'd3, 4'd7), 0, 0, 4'h0);   run_all("and_r4_r3_r7");
    plan(enc_r(OP_ADD, 4'd1, 4'd2, 4'd3), 3, 0, 4'h0);   run_all("fetch_wait3");
    plan(enc_i(OP_LD, 4'd2, 4'd5, 19'h10), 0, 2, 4'h0);  run_all("ld_wait2");
    plan(enc_br(4'd6, 2'b00, 19'h7FFFC), 0, 0, 4'b0001); run_all("br_zero_taken");
    plan(enc_br(4'd6, 2'b00, 19'h7FFFC), 0, 0, 4'b1110); run_all("br_zero_not");
    plan(enc_br(4'd1, 2'b01, 19'h00020), 1, 0, 4'b0010); run_all("br_nzero");
    plan(enc_br(4'd1, 2'b10, 19'h00020), 0, 0, 4'b1011); run_all("br_pos_not");
    plan(enc_br(4'd1, 2'b11, 19'h40000), 0, 0, 4'b1000); run_all("br_neg");
    plan({OP_NOP, 27'h5A5A5A5}, 0, 0, 4'h0);             run_all("nop");
    plan(enc_i(OP_ST, 4'd9, 4'd1, 19'h7FFFF), 0, 1, 4'h0); run_all("st_wait1");
    plan(enc_i(OP_ADDI, 4'd15, 4'd0, 19'h40001), 0, 0, 4'h0); run_all("addi_neg");
    plan(enc_i(OP_ORI, 4'd8, 4'd14, 19'h3FFFF), 2, 0, 4'h0); run_all("ori");
    plan(enc_r(OP_ROL, 4'd0, 4'd15, 4'd15), 0, 0, 4'h0); run_all("rol");

    for (int n = 0; n < 200; n++) begin
      ir = $urandom;
      ir[31:27] = 5'($urandom_range(0, 14));
      plan(ir, $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom));
      run_all("random");
    end

    plan(enc_i(OP_ST, 4'd3, 4'd4, 19'h8), 0, 3, 4'h0);
    reset_mid(4, "reset_mid_mem_st");
    plan(enc_r(OP_SUB, 4'd5, 4'd6, 4'd7), 0, 0, 4'h0);
    reset_mid(4, "reset_mid_wbwrite");

    plan({5'd22, 27'h1234567}, 0, 0, 4'h0); run_all("undef_halt");
    do_reset(2, "reset_from_halt");
    plan({OP_HALT, 27'h0000ABC}, 1, 0, 4'h0); run_all("halt_op");
    do_reset(1, "reset_from_halt2");
    plan(enc_r(OP_SHR, 4'd12, 4'd11, 4'd10), 0, 0, 4'h0); run_all("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
